// File: rtl/dest_reg_tracker_if.sv
// rtl/dest_reg_tracker_if.sv - EX/ID hazard inputs and forward/stall/writeback outputs
interface dest_reg_tracker_if;
  logic [4:0] ex_write_reg;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_flush;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic [4:0] wb_write_reg;
  logic       wb_reg_write;
  logic [7:0] stall_cnt;
  // Observation of the MEM slot flags, so flush squashing is visible.
  logic       mem_reg_write;
  logic       mem_mem_read;

  modport master (
    output ex_write_reg, ex_reg_write, ex_mem_read, ex_flush,
    output ex_rs, ex_rt, id_rs, id_rt,
    input  fwd_a, fwd_b, stall, wb_write_reg, wb_reg_write, stall_cnt,
    input  mem_reg_write, mem_mem_read
  );

  modport slave (
    input  ex_write_reg, ex_reg_write, ex_mem_read, ex_flush,
    input  ex_rs, ex_rt, id_rs, id_rt,
    output fwd_a, fwd_b, stall, wb_write_reg, wb_reg_write, stall_cnt,
    output mem_reg_write, mem_mem_read
  );
endinterface

// File: rtl/dest_reg_tracker.sv
// rtl/dest_reg_tracker.sv - MEM/WB destination tracking, operand forwarding and load-use stall
module dest_reg_tracker (
  input  logic               clk,
  input  logic               rst_n,
  dest_reg_tracker_if.slave  bus
);

  logic [4:0] mem_reg;
  logic       mem_rw;
  logic       mem_mr;
  logic [4:0] wb_reg;
  logic       wb_rw;
  logic [7:0] stall_cnt;

  logic       mem_eff;
  logic       wb_eff;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;

  // Register 0 is hardwired, so a slot writing it is never a hazard source.
  assign mem_eff = mem_rw && (mem_reg != 5'd0);
  assign wb_eff  = wb_rw && (wb_reg != 5'd0);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_eff && (mem_reg == bus.ex_rs))     fwd_a = 2'b10;
    else if (wb_eff && (wb_reg == bus.ex_rs))  fwd_a = 2'b01;
    if (mem_eff && (mem_reg == bus.ex_rt))     fwd_b = 2'b10;
    else if (wb_eff && (wb_reg == bus.ex_rt))  fwd_b = 2'b01;
  end

  assign stall = bus.ex_mem_read && bus.ex_reg_write && !bus.ex_flush &&
                 (bus.ex_write_reg != 5'd0) &&
                 ((bus.ex_write_reg == bus.id_rs) || (bus.ex_write_reg == bus.id_rt));

  // The load keeps advancing during a stall; the bubble is inserted upstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_reg   <= 5'd0;
      mem_rw    <= 1'b0;
      mem_mr    <= 1'b0;
      wb_reg    <= 5'd0;
      wb_rw     <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      wb_reg  <= mem_reg;
      wb_rw   <= mem_rw;
      mem_reg <= bus.ex_write_reg;
      mem_rw  <= bus.ex_reg_write & ~bus.ex_flush;
      mem_mr  <= bus.ex_mem_read & ~bus.ex_flush;
      if (stall && (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.stall         = stall;
  assign bus.wb_write_reg  = wb_reg;
  assign bus.wb_reg_write  = wb_rw;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.mem_reg_write = mem_rw;
  assign bus.mem_mem_read  = mem_mr;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// tb/tb_dest_reg_tracker.sv - scoreboard bench for dest_reg_tracker
module tb_dest_reg_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tag = 0;

  always #5 clk = ~clk;

  dest_reg_tracker_if bus ();

  dest_reg_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int         tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [4:0] wr;
    logic       ww;
    logic [7:0] cnt;
    logic       mrw;
    logic       mmr;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int t, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the DUT must show this cycle.
  task automatic cyc(input logic rst, input logic [4:0] wreg, input logic rw, input logic mr,
                     input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] irs, input logic [4:0] irt,
                     input logic [1:0] efa, input logic [1:0] efb, input logic est,
                     input logic [4:0] ewr, input logic eww, input logic [7:0] ecnt,
                     input logic emrw, input logic emmr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst;
    bus.ex_write_reg = wreg;
    bus.ex_reg_write = rw;
    bus.ex_mem_read  = mr;
    bus.ex_flush     = fl;
    bus.ex_rs        = rs;
    bus.ex_rt        = rt;
    bus.id_rs        = irs;
    bus.id_rt        = irt;
    tag++;
    e.tag = tag; e.fa = efa; e.fb = efb; e.st = est; e.wr = ewr; e.ww = eww;
    e.cnt = ecnt; e.mrw = emrw; e.mmr = emmr;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_a",        e.tag, {6'd0, bus.fwd_a},        {6'd0, e.fa});
        chk("fwd_b",        e.tag, {6'd0, bus.fwd_b},        {6'd0, e.fb});
        chk("stall",        e.tag, {7'd0, bus.stall},        {7'd0, e.st});
        chk("wb_write_reg", e.tag, {3'd0, bus.wb_write_reg}, {3'd0, e.wr});
        chk("wb_reg_write", e.tag, {7'd0, bus.wb_reg_write}, {7'd0, e.ww});
        chk("stall_cnt",    e.tag, bus.stall_cnt,            e.cnt);
        chk("mem_rw",       e.tag, {7'd0, bus.mem_reg_write}, {7'd0, e.mrw});
        chk("mem_mr",       e.tag, {7'd0, bus.mem_mem_read},  {7'd0, e.mmr});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.ex_write_reg = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.ex_flush = 1'b0; bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    repeat (2) @(posedge clk);

    //  rst wreg rw mr fl rs  rt  irs irt | fa     fb     st wr  ww cnt   mrw mmr
    // Reset state, and stall tracking inputs while reset is held
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    cyc(0, 3, 1, 1, 0, 0, 0, 3, 0,   2'b00, 2'b00, 1, 0, 0, 8'd0, 0, 0);
    // Single write to r8, then consume it from MEM and from WB
    cyc(1, 8, 1, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8, 0, 0, 0,   2'b10, 2'b00, 0, 0, 0, 8'd0, 1, 0);
    cyc(1, 0, 0, 0, 0, 8, 0, 0, 0,   2'b01, 2'b00, 0, 8, 1, 8'd0, 0, 0);
    cyc(1, 0, 0, 0, 0, 8, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    // Back-to-back writes to r5: the newest (MEM) wins
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 5, 0, 0,   2'b00, 2'b10, 0, 0, 0, 8'd0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5, 0, 0,   2'b00, 2'b10, 0, 5, 1, 8'd0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 5, 0, 0,   2'b00, 2'b01, 0, 5, 1, 8'd0, 0, 0);
    // Loads/writes to r0 never forward or stall
    cyc(1, 0, 1, 1, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 1, 8'd0, 0, 0);
    // Load-use hazard on id_rt, then the same with a flush
    cyc(1, 9, 1, 1, 0, 0, 0, 0, 9,   2'b00, 2'b00, 1, 0, 0, 8'd0, 0, 0);
    cyc(1, 9, 1, 1, 1, 0, 0, 0, 9,   2'b00, 2'b00, 0, 0, 0, 8'd1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 9, 1, 8'd1, 0, 0);
    // A load in MEM forwards like any other writer
    cyc(1, 4, 1, 1, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 9, 0, 8'd1, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 4, 0, 0,   2'b10, 2'b10, 0, 0, 0, 8'd1, 1, 1);
    cyc(1, 0, 0, 0, 0, 4, 0, 0, 0,   2'b01, 2'b00, 0, 4, 1, 8'd1, 0, 0);
    // Sustained stall: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      cyc(1, 7, 1, 1, 0, 0, 0, 7, 0, 2'b00, 2'b00, 1,
          (i >= 2) ? 5'd7 : 5'd0, (i >= 2) ? 1'b1 : 1'b0,
          (i + 1 > 255) ? 8'd255 : 8'(i + 1),
          (i >= 1) ? 1'b1 : 1'b0, (i >= 1) ? 1'b1 : 1'b0);
    end
    // Reset with both slots effective discards them
    cyc(0, 0, 0, 0, 0, 7, 7, 0, 0,   2'b10, 2'b10, 0, 7, 1, 8'd255, 1, 1);
    cyc(1, 0, 0, 0, 0, 7, 7, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    // Reset pulse that ends before the next edge has no effect
    cyc(1, 6, 1, 0, 0, 0, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 8'd0, 0, 0);
    cyc(0, 0, 0, 0, 0, 6, 0, 0, 0,   2'b10, 2'b00, 0, 0, 0, 8'd0, 1, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 6, 0, 0, 0,   2'b01, 2'b00, 0, 6, 1, 8'd0, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", tag, 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dest_reg_tracker.md
DEST_REG_TRACKER -- requirements
Module: dest_reg_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk only.
REQ-003 ex_write_reg  input  5  destination register chosen by the EX-stage rt/rd select.
REQ-004 ex_reg_write  input  1  EX instruction writes the register file.
REQ-005 ex_mem_read  input  1  EX instruction is a load.
REQ-006 ex_flush  input  1  kill the EX instruction (branch taken).
REQ-007 ex_rs, ex_rt  input  5 each  source registers of the EX instruction.
REQ-008 id_rs, id_rt  input  5 each  source registers of the ID instruction.
REQ-009 fwd_a, fwd_b  output  2 each  ALU operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-010 stall  output  1  load-use hazard; hold PC and IF/ID and bubble ID/EX.
REQ-011 wb_write_reg  output  5  register-file write address.
REQ-012 wb_reg_write  output  1  register-file write enable.
REQ-013 stall_cnt  output  8  saturating count of stall cycles.

Function
REQ-014 The block SHALL hold two slots, MEM and WB, each with reg[4:0], rw, and mr (MEM slot only).
REQ-015 On every non-reset edge, the WB slot SHALL load the MEM slot, and the MEM slot SHALL load {ex_write_reg, ex_reg_write & ~ex_flush, ex_mem_read & ~ex_flush}.
REQ-016 wb_write_reg and wb_reg_write SHALL be the registered WB slot, giving two cycles of latency from EX.
REQ-017 A slot SHALL be effective only if rw=1 and reg!=0; register 0 SHALL never forward or stall.
REQ-018 fwd_a SHALL be 10 if the MEM slot is effective and MEM.reg==ex_rs, else 01 if the WB slot is effective and WB.reg==ex_rs, else 00 (combinational).
REQ-019 When both slots match, MEM SHALL take priority.
REQ-020 fwd_b SHALL follow the same rules as fwd_a, using ex_rt.
REQ-021 stall SHALL be combinational: ex_mem_read & ex_reg_write & ~ex_flush & ex_write_reg!=0 & (ex_write_reg==id_rs | ex_write_reg==id_rt).
REQ-022 While stall is asserted, slot shifting SHALL continue unchanged, because the load advances; the bubble behind it is created upstream.
REQ-023 stall_cnt SHALL increment on each edge where stall=1 and SHALL saturate at 255 without wrapping.
REQ-024 If ex_flush and a hazard condition coincide, stall SHALL be 0 and the MEM slot SHALL capture rw=0 and mr=0.
REQ-025 A load in the MEM slot SHALL forward to EX as 10 like any other instruction; the data-path correctness of that case is guaranteed by the earlier stall.

Reset
REQ-026 When rst_n=0 at an edge, both slots SHALL clear to reg=0, rw=0, mr=0, and stall_cnt SHALL clear to 0.
REQ-027 After reset, wb_write_reg=0, wb_reg_write=0, fwd_a=fwd_b=00, and stall is driven by the current inputs only.
REQ-028 Reset asserted mid-operation SHALL discard in-flight slots at that edge; no write enable SHALL appear afterward until a new instruction passes through.
REQ-029 rst_n deassertion SHALL take effect at the next edge, and the shift SHALL resume on the first edge with rst_n=1.

Verification
REQ-030 Scenario: ex_write_reg=8, ex_reg_write=1 for one cycle, then ex_rs=8 -> fwd_a=10 in the next cycle, fwd_a=01 one cycle later, and wb_write_reg=8 with wb_reg_write=1 two edges after issue.
REQ-031 Scenario: back-to-back writes to r5 (A then B), then ex_rt=5 -> fwd_b=10 (newest wins) and never 01 while both slots hold r5.
REQ-032 Scenario: ex_mem_read=1, ex_reg_write=1, ex_write_reg=9, id_rt=9 -> stall=1 in the same cycle and stall_cnt=1 after the edge; the same stimulus with ex_flush=1 -> stall=0 and the MEM slot rw=0.
REQ-033 Scenario: writes to r0 with ex_reg_write=1 and ex_rs=0 -> fwd_a=00 and stall=0 even when ex_mem_read=1 and id_rs=0.
REQ-034 Scenario: hold the stall condition for 300 cycles -> stall_cnt reaches 255 and stays at 255.
REQ-035 Scenario: rst_n=0 for one edge while both slots are effective -> wb_reg_write=0 and fwd_a=fwd_b=00 next cycle; rst_n=0 while clk is not rising -> no change until the next edge.
